branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor and EX-stage misprediction checker for the RISC-V pipeline. It is a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. The IF stage looks it up by PC to choose the next fetch address. The EX stage reports each resolved branch or jump, and the block trains its tables from that report. It also raises mispredict with the correct redirect PC, and keeps saturating performance counters.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/sat_counter.sv | 33 +++
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// +----------------------------------------------------------------------+
// | bp_pkg: shared types and helpers for the BTB branch predictor        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Widest tag any legal PC_W can produce; the block zero-extends its tag into it.
  localparam int BTB_TAG_MAX = 32;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    logic [1:0]             ctr;
    logic                   is_jump;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter: increment-enabled counter that sticks at all-ones       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +----------------------------------------------------------------------+
// | branch_predictor: direct-mapped BTB with 2-bit counters, EX checker  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_is_jump,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] br_count,
  output logic [PERF_W-1:0] mis_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];

  btb_entry_t             if_ent;
  btb_entry_t             ex_ent;
  btb_entry_t             upd_d;
  logic                   upd_we;
  logic [IDX_W-1:0]       if_idx;
  logic [IDX_W-1:0]       ex_idx;
  logic [BTB_TAG_MAX-1:0] if_tag;
  logic [BTB_TAG_MAX-1:0] ex_tag;
  logic                   if_hit;
  logic                   ex_hit;
  logic                   unused_if_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_tag = BTB_TAG_MAX'(if_pc[PC_W-1:IDX_W+2]);
  assign ex_tag = BTB_TAG_MAX'(ex_pc[PC_W-1:IDX_W+2]);
  assign unused_if_pc_bits = ^if_pc[1:0];

  // Lookup reads the registered table directly, so a same-cycle update is not bypassed.
  assign if_ent = btb_q[if_idx];
  assign ex_ent = btb_q[ex_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  assign pred_taken  = bp_en && if_hit && (if_ent.is_jump || if_ent.ctr[1]);
  assign pred_target = pred_taken ? if_ent.target : 32'd0;

  assign mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : (32'(ex_pc) + 32'd4);

  always_comb begin
    upd_d  = ex_ent;
    upd_we = 1'b0;
    if (ex_valid) begin
      if (ex_hit) begin
        upd_we        = 1'b1;
        upd_d.ctr     = ex_is_jump ? ST : ctr_next(ex_ent.ctr, ex_taken);
        upd_d.is_jump = ex_is_jump;
        if (ex_taken) upd_d.target = ex_target;
      end else if (ex_taken) begin
        upd_we        = 1'b1;
        upd_d.valid   = 1'b1;
        upd_d.tag     = ex_tag;
        upd_d.target  = ex_target;
        upd_d.is_jump = ex_is_jump;
        upd_d.ctr     = ex_is_jump ? ST : WT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: WNT, is_jump: 1'b0};
      end
    end else if (upd_we) begin
      btb_q[ex_idx] <= upd_d;
    end
  end

  sat_counter #(.WIDTH(PERF_W)) u_br_count (
    .clk     (clk),
    .rst_n   (reset_n),
    .inc_i   (ex_valid),
    .count_o (br_count)
  );

  sat_counter #(.WIDTH(PERF_W)) u_mis_count (
    .clk     (clk),
    .rst_n   (reset_n),
    .inc_i   (mispredict),
    .count_o (mis_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// +----------------------------------------------------------------------+
// | tb_branch_predictor: directed + random check against a table model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_branch_predictor;

  localparam int PC_W   = 9;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              bp_en = 1'b1;
  logic [PC_W-1:0]   if_pc = '0;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              ex_valid = 1'b0;
  logic [PC_W-1:0]   ex_pc = '0;
  logic              ex_is_jump = 1'b0;
  logic              ex_taken = 1'b0;
  logic [31:0]       ex_target = '0;
  logic              ex_pred_taken = 1'b0;
  logic [31:0]       ex_pred_target = '0;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic [PERF_W-1:0] br_count;
  logic [PERF_W-1:0] mis_count;

  int vectors = 0;
  int errors  = 0;

  // Reference table: one slot per index, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  int          m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_jump  [16];
  int          m_br;
  int          m_mis;

  branch_predictor #(.PC_W(PC_W), .ENTRIES(16), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bp_en          (bp_en),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_jump     (ex_is_jump),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mis_count      (mis_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; m_jump[i] = 0;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic logic m_pred(input int pc, input logic en, output logic [31:0] tgt);
    int  i;
    bit  t;
    i   = (pc / 4) % 16;
    t   = en && m_valid[i] && (m_tag[i] == pc / 64) && (m_jump[i] || m_ctr[i] >= 2);
    tgt = t ? m_tgt[i] : 32'd0;
    return t;
  endfunction

  function automatic logic m_mispred();
    return ex_valid && ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
  endfunction

  function automatic void m_update();
    int i;
    if (!ex_valid) return;
    i = (int'(ex_pc) / 4) % 16;
    if (m_br < 15) m_br++;
    if (m_mispred() && m_mis < 15) m_mis++;
    if (m_valid[i] && m_tag[i] == int'(ex_pc) / 64) begin
      if (ex_is_jump)    m_ctr[i] = 3;
      else if (ex_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      if (ex_taken) m_tgt[i] = ex_target;
      m_jump[i] = ex_is_jump;
    end else if (ex_taken) begin
      m_valid[i] = 1; m_tag[i] = int'(ex_pc) / 64; m_tgt[i] = ex_target;
      m_jump[i] = ex_is_jump; m_ctr[i] = ex_is_jump ? 3 : 2;
    end
  endfunction

  task automatic check_outputs();
    logic        ep;
    logic [31:0] et;
    ep = m_pred(int'(if_pc), bp_en, et);
    check("pred_taken", 32'(pred_taken), 32'(ep));
    check("pred_target", pred_target, et);
    check("mispredict", 32'(mispredict), 32'(m_mispred()));
    check("redirect_pc", redirect_pc, ex_taken ? ex_target : 32'(ex_pc) + 32'd4);
    check("br_count", 32'(br_count), 32'(m_br));
    check("mis_count", 32'(mis_count), 32'(m_mis));
  endtask

  // One cycle: drive, check combinational view, clock, advance the model.
  task automatic step(input logic [8:0] ipc, input logic en, input logic v,
                      input logic [8:0] epc, input logic j, input logic t,
                      input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    if_pc = ipc; bp_en = en; ex_valid = v; ex_pc = epc; ex_is_jump = j;
    ex_taken = t; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
    check_outputs();
    @(posedge clk);
    m_update();
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [8:0]  rpc;
    logic        rp;
    logic [31:0] rpt;

    m_reset();
    #12;
    check("reset_pred_taken", 32'(pred_taken), 32'd0);
    check("reset_br_count", 32'(br_count), 32'd0);
    reset_n = 1'b1;
    #1;

    step(9'h040, 1, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);
    // Cold taken branch
    step(9'h040, 1, 1, 9'h040, 0, 1, 32'h080, 0, 32'h0);
    step(9'h040, 1, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);
    check("cold_pred", 32'(pred_taken), 32'd1);
    check("cold_target", pred_target, 32'h080);
    // Hysteresis: NT, T, T, NT, NT
    step(9'h040, 1, 1, 9'h040, 0, 0, 32'h0, 1, 32'h080);
    check("hyst_nt_pred", 32'(pred_taken), 32'd0);
    step(9'h040, 1, 1, 9'h040, 0, 1, 32'h080, 0, 32'h0);
    step(9'h040, 1, 1, 9'h040, 0, 1, 32'h080, 1, 32'h080);
    step(9'h040, 1, 1, 9'h040, 0, 0, 32'h0, 1, 32'h080);
    step(9'h040, 1, 1, 9'h040, 0, 0, 32'h0, 1, 32'h080);
    step(9'h040, 1, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);
    // JALR at 0x100 aliases index 0; allocate then mistrain target
    step(9'h100, 1, 1, 9'h100, 1, 1, 32'h020, 0, 32'h0);
    step(9'h100, 1, 1, 9'h100, 1, 1, 32'h030, 1, 32'h020);
    step(9'h100, 1, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);
    check("jalr_target", pred_target, 32'h030);
    // bp_en=0 on a trained hit
    step(9'h100, 0, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);
    // Read-during-write at the same index, then the new entry next cycle
    step(9'h084, 1, 1, 9'h184, 0, 1, 32'h1F0, 0, 32'h0);
    step(9'h184, 1, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);

    for (int n = 0; n < 150; n++) begin
      r   = $urandom;
      rpc = 9'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2));
      rp  = m_pred(int'(rpc), 1'b1, rpt);
      if (r[0]) begin
        rp  = r[1];
        rpt = {$urandom_range(0, 3), 2'b00};
      end
      step(9'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2)), r[2] | r[3],
           r[4] | r[5] | r[6], rpc, r[7] & r[8], r[9], {$urandom_range(0, 3), 2'b00}, rp, rpt);
    end
    for (int n = 0; n < 20; n++) begin
      r = $urandom;
      step(9'h040, 1, 1, 9'(n * 4), 0, r[0], 32'h0C0, ~r[0], 32'h0C0);
    end
    check("sat_br", 32'(br_count), 32'hF);
    check("sat_mis", 32'(mis_count), 32'hF);

    // Train a known entry, then assert reset between edges
    step(9'h040, 1, 1, 9'h040, 1, 1, 32'h0A0, 0, 32'h0);
    ex_valid = 1'b0; if_pc = 9'h040; bp_en = 1'b1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m_reset();
    #1;
    check("async_br", 32'(br_count), 32'd0);
    check("async_mis", 32'(mis_count), 32'd0);
    check("async_pred", 32'(pred_taken), 32'd0);
    #7;
    reset_n = 1'b1;
    #1;
    step(9'h040, 1, 0, 9'h000, 0, 0, 32'h0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
